// File: rtl/interrupt_sequencer.sv
// Prioritised interrupt sequencer: waits for an instruction boundary, issues a one-cycle
// vector-call take, and tracks nested in-service levels on a 7-deep level stack.
module interrupt_sequencer #(
   parameter logic [15:0] VECTOR_BASE = 16'h0008
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_int,
   input  logic [2:0]  i_pri,
   input  logic        i_gie,
   input  logic        i_boundary,
   input  logic        i_reti,
   input  logic        i_vec_done,
   output logic        o_take,
   output logic [15:0] o_vector,
   output logic        o_inta,
   output logic [2:0]  o_ack_level,
   output logic [2:0]  o_level,
   output logic [2:0]  o_depth,
   output logic        o_busy,
   output logic        o_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_TAKE = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [2:0]  r_capt;
   logic [2:0]  r_level;
   logic [2:0]  r_depth;
   logic [2:0]  r_ack_level;
   logic [15:0] r_vector;
   logic        r_err;
   logic [2:0]  r_stack [0:6];

   logic        w_elig;
   logic        w_capture;
   logic        w_push;
   logic        w_pop;
   logic        w_err_set;
   logic        w_take;
   logic        w_busy;

   assign w_elig = i_int & i_gie & (i_pri > r_level);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // RETI outranks BOUNDARY in WAIT; the stay/leave decision uses this cycle's ELIG.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err_set = 1'b0;
      w_take    = 1'b0;
      w_busy    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_reti) begin
               if (r_depth != 3'd0) begin
                  w_pop = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end
            if (w_elig) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_reti) begin
               if (r_depth != 3'd0) begin
                  w_pop = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
               w_next = w_elig ? S_WAIT : S_IDLE;
            end else if (!w_elig) begin
               w_next = S_IDLE;
            end else if (i_boundary) begin
               w_capture = 1'b1;
               w_next    = S_TAKE;
            end
         end
         S_TAKE: begin
            w_take    = 1'b1;
            w_busy    = 1'b1;
            w_push    = 1'b1;
            w_err_set = i_reti;
            w_next    = S_HOLD;
         end
         S_HOLD: begin
            w_busy    = 1'b1;
            w_err_set = i_reti;
            if (i_vec_done) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_capt      <= 3'd0;
         r_level     <= 3'd0;
         r_depth     <= 3'd0;
         r_ack_level <= 3'd0;
         r_vector    <= VECTOR_BASE;
         r_err       <= 1'b0;
         for (int k = 0; k < 7; k++) begin
            r_stack[k] <= 3'd0;
         end
      end else begin
         if (w_capture) begin
            r_capt      <= i_pri;
            r_ack_level <= i_pri;
            r_vector    <= VECTOR_BASE + {11'd0, i_pri, 2'b00};
         end
         // Each push needs a strictly higher level, so depth 7 never sees another push.
         if (w_push) begin
            if (r_depth != 3'd7) begin
               r_stack[r_depth] <= r_level;
            end
            r_level <= r_capt;
            r_depth <= r_depth + 3'd1;
         end
         if (w_pop) begin
            r_level <= r_stack[r_depth - 3'd1];
            r_depth <= r_depth - 3'd1;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_take      = w_take;
   assign o_inta      = w_take;
   assign o_busy      = w_busy;
   assign o_vector    = r_vector;
   assign o_ack_level = r_ack_level;
   assign o_level     = r_level;
   assign o_depth     = r_depth;
   assign o_err       = r_err;

endmodule
